// File: rtl/dna_pattern_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : dna_pattern_scanner
//  Purpose  : Streaming sliding-window nucleotide pattern matcher with
//             first-match / count-all modes. Optional approximate matching
//             is enabled by defining DNA_MISMATCH_TOL_EN.
//  Revision : 1.0  initial release
// ============================================================================
module dna_pattern_scanner #(
    parameter int SYM_W   = 2,
    parameter int MAX_PAT = 16,
    parameter int LEN_W   = 16,
    parameter int CNT_W   = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           pat_load,
    input  logic [SYM_W-1:0]               pat_sym,
    input  logic [$clog2(MAX_PAT+1)-1:0]   pat_len,
    input  logic [LEN_W-1:0]               dna_length,
    input  logic                           count_all,
`ifdef DNA_MISMATCH_TOL_EN
    input  logic [$clog2(MAX_PAT+1)-1:0]   max_mismatch,
`endif
    input  logic                           start,
    input  logic                           sym_valid,
    input  logic [SYM_W-1:0]               sym,
    output logic                           sym_ready,
    output logic                           busy,
    output logic                           done,
    output logic                           found_it,
    output logic                           error,
    output logic [LEN_W-1:0]               first_idx,
    output logic [CNT_W-1:0]               match_count
);

    localparam int PL_W = $clog2(MAX_PAT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                         r_state;
    logic [MAX_PAT-1:0][SYM_W-1:0]  r_pat;
    logic [MAX_PAT-2:0][SYM_W-1:0]  r_win;
    logic [MAX_PAT-1:0][SYM_W-1:0]  w_win_next;
    logic [PL_W-1:0]                r_pat_len;
    logic [PL_W-1:0]                r_fill;
    logic [PL_W-1:0]                w_fill_next;
    logic [PL_W-1:0]                w_mm_cnt;
    logic [LEN_W-1:0]               r_dna_len;
    logic [LEN_W-1:0]               r_idx;
    logic [LEN_W-1:0]               r_first_idx;
    logic [CNT_W-1:0]               r_match_count;
    logic                           r_count_all;
    logic                           r_found;
    logic                           r_done;
    logic                           r_busy;
    logic                           r_ready;
    logic                           r_error;
    logic                           w_accept;
    logic                           w_match;
    logic                           w_last;
    logic                           w_cfg_bad;
`ifdef DNA_MISMATCH_TOL_EN
    logic [PL_W-1:0]                r_max_mm;
`endif

    // r_ready is high exactly while in SCAN, so it doubles as the scan qualifier
    assign w_accept    = r_ready && sym_valid;
    assign w_win_next  = {r_win, sym};
    assign w_fill_next = (r_fill < r_pat_len) ? r_fill + PL_W'(1) : r_fill;
    assign w_last      = (r_idx == r_dna_len - LEN_W'(1));
    assign w_cfg_bad   = (pat_len == '0) ||
                         (pat_len > PL_W'(MAX_PAT)) ||
                         (LEN_W'(pat_len) > dna_length);

    always_comb begin
        w_mm_cnt = '0;
        for (int j = 0; j < MAX_PAT; j++) begin
            if ((PL_W'(j) < r_pat_len) && (w_win_next[j] != r_pat[j])) begin
                w_mm_cnt = w_mm_cnt + PL_W'(1);
            end
        end
    end

    // fill saturates at pat_len, so equality means the window is full
`ifdef DNA_MISMATCH_TOL_EN
    assign w_match = (w_fill_next == r_pat_len) && (w_mm_cnt <= r_max_mm);
`else
    assign w_match = (w_fill_next == r_pat_len) && (w_mm_cnt == '0);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pat         <= '0;
            r_win         <= '0;
            r_pat_len     <= '0;
            r_fill        <= '0;
            r_dna_len     <= '0;
            r_idx         <= '0;
            r_first_idx   <= '0;
            r_match_count <= '0;
            r_count_all   <= 1'b0;
            r_found       <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
            r_ready       <= 1'b0;
            r_error       <= 1'b0;
`ifdef DNA_MISMATCH_TOL_EN
            r_max_mm      <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (pat_load) begin
                        r_pat <= {r_pat[MAX_PAT-2:0], pat_sym};
                    end
                    if (start) begin
                        r_pat_len     <= pat_len;
                        r_dna_len     <= dna_length;
                        r_count_all   <= count_all;
`ifdef DNA_MISMATCH_TOL_EN
                        r_max_mm      <= max_mismatch;
`endif
                        r_found       <= 1'b0;
                        r_first_idx   <= '0;
                        r_match_count <= '0;
                        r_fill        <= '0;
                        r_idx         <= '0;
                        r_win         <= '0;
                        if (w_cfg_bad) begin
                            r_state <= S_DONE;
                            r_error <= 1'b1;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b0;
                        end else begin
                            r_state <= S_SCAN;
                            r_error <= 1'b0;
                            r_done  <= 1'b0;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (w_accept) begin
                        r_win  <= w_win_next[MAX_PAT-2:0];
                        r_fill <= w_fill_next;
                        r_idx  <= r_idx + LEN_W'(1);
                        if (w_match) begin
                            if (r_match_count != '1) begin
                                r_match_count <= r_match_count + CNT_W'(1);
                            end
                            if (!r_found) begin
                                r_found     <= 1'b1;
                                r_first_idx <= r_idx - LEN_W'(r_pat_len) + LEN_W'(1);
                            end
                        end
                        if ((w_match && !r_count_all) || w_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign sym_ready   = r_ready;
    assign busy        = r_busy;
    assign done        = r_done;
    assign found_it    = r_found;
    assign error       = r_error;
    assign first_idx   = r_first_idx;
    assign match_count = r_match_count;

endmodule
`default_nettype wire

// File: tb/tb_dna_pattern_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dna_pattern_scanner
//  Purpose  : Directed + randomized self-checking bench for dna_pattern_scanner
//  Revision : 1.0  initial release
// ============================================================================
module tb_dna_pattern_scanner;

    localparam int SYM_W   = 2;
    localparam int MAX_PAT = 16;
    localparam int LEN_W   = 16;
    localparam int CNT_W   = 16;
    localparam int PL_W    = $clog2(MAX_PAT + 1);

    logic               clock      = 1'b0;
    logic               reset      = 1'b1;
    logic               pat_load   = 1'b0;
    logic [SYM_W-1:0]   pat_sym    = '0;
    logic [PL_W-1:0]    pat_len    = '0;
    logic [LEN_W-1:0]   dna_length = '0;
    logic               count_all  = 1'b0;
    logic               start      = 1'b0;
    logic               sym_valid  = 1'b0;
    logic [SYM_W-1:0]   sym        = '0;
    logic               sym_ready;
    logic               busy;
    logic               done;
    logic               found_it;
    logic               error;
    logic [LEN_W-1:0]   first_idx;
    logic [CNT_W-1:0]   match_count;
`ifdef DNA_MISMATCH_TOL_EN
    logic [PL_W-1:0]    max_mismatch = '0;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [SYM_W-1:0] ploads[$];   // every symbol loaded since reset, oldest first
    logic [SYM_W-1:0] seq[64];

    always #5 clock = ~clock;

    dna_pattern_scanner #(
        .SYM_W(SYM_W), .MAX_PAT(MAX_PAT), .LEN_W(LEN_W), .CNT_W(CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pat_load    (pat_load),
        .pat_sym     (pat_sym),
        .pat_len     (pat_len),
        .dna_length  (dna_length),
        .count_all   (count_all),
`ifdef DNA_MISMATCH_TOL_EN
        .max_mismatch(max_mismatch),
`endif
        .start       (start),
        .sym_valid   (sym_valid),
        .sym         (sym),
        .sym_ready   (sym_ready),
        .busy        (busy),
        .done        (done),
        .found_it    (found_it),
        .error       (error),
        .first_idx   (first_idx),
        .match_count (match_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // pattern element j: j=0 is the most recently loaded symbol
    function automatic logic [SYM_W-1:0] pat_at(input int j);
        if (j < ploads.size()) return ploads[ploads.size() - 1 - j];
        return '0;
    endfunction

    task automatic load_pat(input logic [SYM_W-1:0] s);
        pat_sym  = s;
        pat_load = 1'b1;
        @(posedge clock); #1;
        pat_load = 1'b0;
        ploads.push_back(s);
        if (ploads.size() > MAX_PAT) void'(ploads.pop_front());
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ready"}, 32'(sym_ready), 0);
        check_val({tag, "_busy"},  32'(busy), 0);
        check_val({tag, "_done"},  32'(done), 0);
        check_val({tag, "_found"}, 32'(found_it), 0);
        check_val({tag, "_err"},   32'(error), 0);
        check_val({tag, "_first"}, 32'(first_idx), 0);
        check_val({tag, "_count"}, 32'(match_count), 0);
    endtask

    task automatic run_scan(input string tag, input int L, input int N, input bit ca,
                            input int tol, input bit gaps);
        bit exp_err, exp_found, stop;
        int exp_cnt, exp_first, exp_cons, d, idx, cyc;
        exp_err   = (L == 0) || (L > MAX_PAT) || (L > N);
        exp_found = 0;
        exp_cnt   = 0;
        exp_first = 0;
        exp_cons  = N;
        stop      = 0;
        if (!exp_err) begin
            for (int i = 0; i < N && !stop; i++) begin
                if (i + 1 >= L) begin
                    d = 0;
                    for (int k = 0; k < L; k++)
                        if (seq[i - L + 1 + k] != pat_at(L - 1 - k)) d++;
                    if (d <= tol) begin
                        exp_cnt++;
                        if (!exp_found) begin
                            exp_found = 1;
                            exp_first = i - L + 1;
                        end
                        if (!ca) begin
                            exp_cons = i + 1;
                            stop     = 1;
                        end
                    end
                end
            end
        end

        pat_len    = PL_W'(L);
        dna_length = LEN_W'(N);
        count_all  = ca;
`ifdef DNA_MISMATCH_TOL_EN
        max_mismatch = PL_W'(tol);
`endif
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;

        if (exp_err) begin
            check_val({tag, "_err"},   32'(error), 1);
            check_val({tag, "_done"},  32'(done), 1);
            check_val({tag, "_busy"},  32'(busy), 0);
            sym_valid = 1'b1;
            repeat (3) begin
                check_val({tag, "_ready"}, 32'(sym_ready), 0);
                @(posedge clock); #1;
            end
            sym_valid = 1'b0;
            return;
        end

        check_val({tag, "_busy0"}, 32'(busy), 1);
        check_val({tag, "_done0"}, 32'(done), 0);
        idx = 0;
        cyc = 0;
        while (!done && cyc < 4 * N + 20) begin
            sym_valid = gaps ? (cyc % 2 == 1) : ($urandom_range(0, 3) != 0);
            sym       = (idx < 64) ? seq[idx] : SYM_W'($urandom);
            pat_load  = ($urandom_range(0, 3) == 0);
            pat_sym   = SYM_W'($urandom);
            @(posedge clock); #1;
            if (sym_valid) idx++;
            cyc++;
        end
        sym_valid = 1'b0;
        pat_load  = 1'b0;
        check_val({tag, "_done"},  32'(done), 1);
        check_val({tag, "_cons"},  32'(idx), 32'(exp_cons));
        check_val({tag, "_found"}, 32'(found_it), 32'(exp_found));
        check_val({tag, "_first"}, 32'(first_idx), 32'(exp_first));
        check_val({tag, "_count"}, 32'(match_count), 32'(exp_cnt));
        check_val({tag, "_err"},   32'(error), 0);
        check_val({tag, "_busy"},  32'(busy), 0);
        check_val({tag, "_ready"}, 32'(sym_ready), 0);
    endtask

    task automatic set_seq(input int n, input logic [31:0] packed_syms);
        logic [31:0] p;
        p = packed_syms;
        for (int i = 0; i < n; i++) seq[i] = p[2*i +: 2];
    endtask

    initial begin
        int L, N, k, tol;
        bit ca;

        #12;
        check_all_zero("rst");
        @(posedge clock); #1;
        reset = 1'b0;

        // A,C,G vs T,A,C,G,A,C
        load_pat(2'd0); load_pat(2'd1); load_pat(2'd2);
        set_seq(6, {20'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3});
        run_scan("exact", 3, 6, 0, 0, 0);
        run_scan("gaps", 3, 6, 0, 0, 1);

        // A,A overlapping
        load_pat(2'd0); load_pat(2'd0);
        set_seq(4, 32'd0);
        run_scan("overlap", 2, 4, 1, 0, 0);

        // G,G never matches A,C,A,C
        load_pat(2'd2); load_pat(2'd2);
        set_seq(4, {24'd0, 2'd1, 2'd0, 2'd1, 2'd0});
        run_scan("nomatch", 2, 4, 0, 0, 0);

        run_scan("err_long", 5, 3, 0, 0, 0);
        run_scan("err_zero", 0, 4, 0, 0, 0);
        run_scan("err_max", MAX_PAT + 1, 40, 1, 0, 0);

        // asynchronous reset after the second symbol
        pat_len = 3; dna_length = 6; count_all = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        sym_valid = 1'b1;
        repeat (2) begin
            sym = 2'd0;
            @(posedge clock); #1;
        end
        sym_valid = 1'b0;
        #2 reset = 1'b1;
        #1 check_all_zero("midrst");
        ploads.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check_all_zero("idle");

`ifdef DNA_MISMATCH_TOL_EN
        load_pat(2'd0); load_pat(2'd1); load_pat(2'd2);
        set_seq(3, {26'd0, 2'd2, 2'd3, 2'd0});
        run_scan("tol1", 3, 3, 0, 1, 0);
        run_scan("tol0", 3, 3, 0, 0, 0);
`endif

        for (int it = 0; it < 40; it++) begin
            L = $urandom_range(1, 5);
            N = $urandom_range(L, L + 25);
            if ($urandom_range(0, 9) == 0) L = ($urandom_range(0, 1) == 0) ? 0 : N + 1;
            k = $urandom_range(0, 7);
            for (int j = 0; j < k; j++) load_pat(SYM_W'($urandom_range(0, 1)));
            for (int j = 0; j < N; j++)
                seq[j] = (it % 2 == 0) ? SYM_W'($urandom_range(0, 1)) : SYM_W'($urandom);
            ca = $urandom_range(0, 1);
`ifdef DNA_MISMATCH_TOL_EN
            tol = $urandom_range(0, 2);
`else
            tol = 0;
`endif
            run_scan($sformatf("rnd%0d", it), L, N, ca, tol, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dna_pattern_scanner.md
Name: dna_pattern_scanner

Overview:
- Streaming, parametrised nucleotide pattern matcher. Successor to the fixed-width memory-driven DNA search.
- Accepts the sequence one symbol per cycle over a valid/ready handshake and compares it against a programmable pattern of up to MAX_PAT symbols using a sliding window.
- Reports first-match index and total (overlapping) match count; selectable first-match or count-all mode.
- Sits between the sequence memory/reader and the control FSM of the search datapath.

Parameters:
- SYM_W, 2: bits per nucleotide symbol (A=0, C=1, G=2, T=3 at default).
- MAX_PAT, 16: maximum pattern length in symbols.
- LEN_W, 16: width of sequence length and index.
- CNT_W, 16: width of match counter.

Ports:
- clock, input, 1: single clock, rising edge.
- reset, input, 1: reset, asynchronous, active-high.
- pat_load, input, 1: shift pat_sym into pattern register.
- pat_sym, input, SYM_W: pattern symbol.
- pat_len, input, $clog2(MAX_PAT+1): active pattern length; sampled at start.
- dna_length, input, LEN_W: number of sequence symbols; sampled at start.
- count_all, input, 1: 0 = stop at first match, 1 = scan whole sequence; sampled at start.
- start, input, 1: begin scan.
- sym_valid, input, 1: sequence symbol valid.
- sym, input, SYM_W: sequence symbol.
- sym_ready, output, 1: scanner accepts symbol.
- busy, output, 1: scan in progress.
- done, output, 1: scan finished (level).
- found_it, output, 1: at least one match.
- error, output, 1: illegal configuration.
- first_idx, output, LEN_W: 0-based start index of first match.
- match_count, output, CNT_W: number of matches.

Behaviour:
- **Reset:**
  - All outputs 0.
  - Pattern register, window, counters and state cleared; state = IDLE.
  - Reset mid-scan aborts immediately; no partial result is retained.
- **States:** IDLE, SCAN, DONE.
- **Pattern load:**
  - pat_load is honoured only in IDLE or DONE; it is ignored in SCAN.
  - Each load shifts the new symbol into pat[0]; older symbols move to higher indices.
  - If more than pat_len symbols are loaded, the most recent pat_len symbols are used.
- **Start (IDLE or DONE):**
  - Samples pat_len, dna_length and count_all.
  - Clears found_it, first_idx, match_count, window fill and symbol index.
  - If pat_len==0, pat_len>MAX_PAT or pat_len>dna_length: go to DONE next cycle with error=1 and done=1; sym_ready never asserts.
  - Otherwise go to SCAN; done=0, error=0, busy=1.
  - start is ignored while in SCAN.
- **SCAN:**
  - sym_ready=1. A symbol is accepted on an edge where sym_valid && sym_ready.
  - The accepted symbol shifts into win[0]. The fill count saturates at pat_len. The symbol index i increments.
  - Match condition: fill (including this symbol) >= pat_len and win[j]==pat[j] for all j<pat_len.
  - Matches may overlap.
  - On a match:
    - match_count increments, saturating at all-ones.
    - On the first match only, found_it=1 and first_idx=i-pat_len+1.
    - Both are registered on the same edge as acceptance.
  - Exit conditions:
    - count_all=0: a match moves the FSM to DONE on the same edge.
    - Otherwise, acceptance of symbol dna_length-1 moves the FSM to DONE.
    - A match on the final symbol is counted.
  - No state change on cycles without acceptance (valid gaps tolerated).
- **DONE:**
  - done=1, busy=0, sym_ready=0.
  - Results are held until the next start or reset.
- **Latency:** done is visible the cycle after the final accepted symbol.

Optional Feature:
- Macro: DNA_MISMATCH_TOL_EN.
- When defined:
  - Adds input port max_mismatch, width $clog2(MAX_PAT+1), sampled at start.
  - A match occurs when the count of positions j<pat_len with win[j]!=pat[j] is <= max_mismatch.
  - Error rules are unchanged.
- When undefined:
  - The port is absent and only exact matches count.

Test Plan:
- Exact, first-match mode:
  - Stimulus: load A,C,G; pat_len=3; dna_length=6; count_all=0; stream T,A,C,G,A,C.
  - Response: found_it=1, first_idx=1, match_count=1; done the cycle after the 4th accepted symbol; sym_ready=0 thereafter.
- Overlap, count-all mode:
  - Stimulus: load A,A; pat_len=2; dna_length=4; count_all=1; stream A,A,A,A.
  - Response: match_count=3, first_idx=0, found_it=1; done after the 4th symbol.
- No match:
  - Stimulus: load G,G; pat_len=2; stream A,C,A,C with dna_length=4.
  - Response: found_it=0, match_count=0, error=0; done after the 4th symbol.
- Error configurations:
  - Stimulus: pat_len=5 with dna_length=3, then separately pat_len=0.
  - Response: error=1 and done=1 one cycle after start; sym_ready stays 0.
- Handshake and reset:
  - Stimulus: repeat the first scenario with sym_valid low on alternate cycles.
  - Response: results identical to the first scenario.
  - Stimulus: assert reset after the 2nd symbol.
  - Response: all outputs 0 asynchronously; FSM in IDLE.
- With DNA_MISMATCH_TOL_EN:
  - Stimulus: pattern A,C,G; max_mismatch=1; stream A,T,G.
  - Response: found_it=1, first_idx=0.
  - Stimulus: same stream with max_mismatch=0.
  - Response: found_it=0.
